// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if
//   Bus bundle between a sync_fifo_param instance and its producer/consumer.
//   master : producer/consumer side (drives requests, write data, clr_err)
//   slave  : FIFO side (drives read data, status flags, level, error flags)
//   Signals: wr_en, data_in, rd_en, data_out, full, empty, almost_full,
//            almost_empty, level[AW:0], overflow, underflow, clr_err
interface sync_fifo_param_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
);
    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [AW:0]      level;
    logic             overflow;
    logic             underflow;
    logic             clr_err;

    modport master (
        output wr_en, data_in, rd_en, clr_err,
        input  data_out, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en, clr_err,
        output data_out, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Parametrised single-clock FIFO with same-cycle status flags, fill level,
//   programmable almost thresholds, sticky overflow/underflow flags and an
//   optional first-word-fall-through read mode.
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous reset, active-high
//     bus  : sync_fifo_param_if.slave (requests, data, flags, level, errors)
module sync_fifo_param #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int AW     = $clog2(DEPTH),
    parameter int AF_THR = DEPTH - 2,
    parameter int AE_THR = 2,
    parameter bit FWFT   = 1'b0
) (
    input logic              clk,
    input logic              rst,
    sync_fifo_param_if.slave bus
);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_AF   = (AW+1)'(AF_THR);
    localparam logic [AW:0] LVL_AE   = (AW+1)'(AE_THR);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;
    logic             full;
    logic             empty;
    logic             wr_acc;
    logic             rd_acc;
    logic             overflow_q;
    logic             underflow_q;

    // Flags decode the registered level directly, so they never lag it.
    always_comb begin
        full   = (level == LVL_FULL);
        empty  = (level == '0);
        wr_acc = bus.wr_en & ~full;
        rd_acc = bus.rd_en & ~empty;
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (level >= LVL_AF);
    assign bus.almost_empty = (level <= LVL_AE);
    assign bus.level        = level;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    // Storage is not reset; writes are still suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // DEPTH is a power of two, so pointer wrap is natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sticky errors; a new error in the same cycle as clr_err takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.clr_err) begin
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end
            if (bus.wr_en && full)  overflow_q  <= 1'b1;
            if (bus.rd_en && empty) underflow_q <= 1'b1;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is presented combinationally; rd_en only pops it.
            assign bus.data_out = mem[rd_ptr];
        end else begin : g_reg
            logic [WIDTH-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= mem[rd_ptr];
                end
            end
            assign bus.data_out = dout_q;
        end
    endgenerate
endmodule
